// File: rtl/floor_request_latch.sv
// floor_request_latch
//   Front end of the elevator controller. Raw call keys are synchronised and
//   debounced per floor; each accepted press latches a pending request in
//   `buttons`. When the car sits at a requested floor the request is held for
//   a door dwell and then cleared.
//   Optional feature macro: REQ_CANCEL_EN. When it is defined, pressing an
//   already-pending floor cancels that request, except for the floor being
//   served, where a press only re-opens the door.
module floor_request_latch #(
  parameter int FLOORS          = 10,
  parameter int LAYER_W         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DOOR_CYCLES     = 8
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [FLOORS-1:0]  key_in,
  input  logic [LAYER_W-1:0] Layer,
  output logic [FLOORS-1:0]  buttons,
  output logic               door_open,
  output logic [LAYER_W-1:0] dwell_floor
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DOOR_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  // Debounce front end state
  logic [FLOORS-1:0] sync1_r;
  logic [FLOORS-1:0] sync2_r;
  logic [FLOORS-1:0] stable_r;
  logic [FLOORS-1:0] press_r;
  logic [CNT_W-1:0]  cnt_r [FLOORS];

  // Request / dwell state
  state_t            state_r;
  state_t            state_nx_s;
  logic [TMR_W-1:0]  timer_r;
  logic [TMR_W-1:0]  timer_nx_s;
  logic              door_nx_s;
  logic [LAYER_W-1:0] dwell_nx_s;
  logic [FLOORS-1:0] buttons_nx_s;
  logic [FLOORS-1:0] clear_s;
  logic [FLOORS-1:0] dwell_mask_s;
  logic              layer_hit_s;
`ifdef REQ_CANCEL_EN
  logic [FLOORS-1:0] cancel_s;
  logic [FLOORS-1:0] protect_s;
`endif

  // Two-stage synchroniser, per-key stable-level counter and press pulse.
  // The press pulse is registered on the same edge the stable level flips to 1.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync1_r  <= '0;
      sync2_r  <= '0;
      stable_r <= '0;
      press_r  <= '0;
      for (int i = 0; i < FLOORS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
      for (int i = 0; i < FLOORS; i++) begin
        if (sync2_r[i] != stable_r[i]) begin
          if (cnt_r[i] == CNT_LAST) begin
            stable_r[i] <= sync2_r[i];
            cnt_r[i]    <= '0;
            press_r[i]  <= sync2_r[i];
          end else begin
            cnt_r[i]    <= cnt_r[i] + CNT_W'(1);
            press_r[i]  <= 1'b0;
          end
        end else begin
          cnt_r[i]   <= '0;
          press_r[i] <= 1'b0;
        end
      end
    end
  end

  // Floor match and one-hot of the floor being served.
  always_comb begin
    layer_hit_s  = 1'b0;
    dwell_mask_s = {{(FLOORS-1){1'b0}}, 1'b1} << dwell_floor;
    if (32'(Layer) < FLOORS) begin
      layer_hit_s = buttons[Layer];
    end else begin
      layer_hit_s = 1'b0;
    end
  end

  // Dwell FSM next state: enter on a pending floor, count down, re-open on re-press.
  // At timer expiry the request is cleared even if a re-press lands on that edge;
  // the request-vector update lets the set win so IDLE re-enters the dwell.
  always_comb begin
    state_nx_s = state_r;
    timer_nx_s = timer_r;
    door_nx_s  = door_open;
    dwell_nx_s = dwell_floor;
    clear_s    = '0;
    case (state_r)
      ST_IDLE: begin
        if (layer_hit_s) begin
          state_nx_s = ST_DWELL;
          door_nx_s  = 1'b1;
          dwell_nx_s = Layer;
          timer_nx_s = TMR_LOAD;
        end else begin
          door_nx_s  = 1'b0;
        end
      end
      ST_DWELL: begin
        if (timer_r == '0) begin
          clear_s    = dwell_mask_s;
          door_nx_s  = 1'b0;
          state_nx_s = ST_IDLE;
        end else if (press_r[dwell_floor]) begin
          timer_nx_s = TMR_LOAD;
          door_nx_s  = 1'b1;
        end else begin
          timer_nx_s = timer_r - TMR_W'(1);
          door_nx_s  = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        door_nx_s  = 1'b0;
      end
    endcase
  end

  // Request vector update: presses set, dwell expiry clears, set beats clear.
  always_comb begin
`ifdef REQ_CANCEL_EN
    protect_s = '0;
    if (state_r == ST_DWELL) begin
      protect_s = dwell_mask_s;
    end else begin
      protect_s = '0;
    end
    cancel_s     = press_r & buttons & ~protect_s;
    buttons_nx_s = ((buttons & ~clear_s) | press_r) & ~cancel_s;
`else
    buttons_nx_s = (buttons & ~clear_s) | press_r;
`endif
  end

  // Registered FSM state, timer and all outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      timer_r     <= '0;
      door_open   <= 1'b0;
      dwell_floor <= '0;
      buttons     <= '0;
    end else begin
      state_r     <= state_nx_s;
      timer_r     <= timer_nx_s;
      door_open   <= door_nx_s;
      dwell_floor <= dwell_nx_s;
      buttons     <= buttons_nx_s;
    end
  end

endmodule

// File: tb/tb_floor_request_latch.sv
// tb_floor_request_latch
//   Directed bench for floor_request_latch with default parameters.
//   Honours REQ_CANCEL_EN when it is defined for the build.
module tb_floor_request_latch;

  logic       CLK;
  logic       Reset;
  logic [9:0] key_in;
  logic [3:0] Layer;
  logic [9:0] buttons;
  logic       door_open;
  logic [3:0] dwell_floor;

  int n_cmp;
  int n_err;
  int door_cnt;
  logic [9:0] exp_b7;

  floor_request_latch dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .key_in      (key_in),
    .Layer       (Layer),
    .buttons     (buttons),
    .door_open   (door_open),
    .dwell_floor (dwell_floor)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, returning 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Main directed sequence
  initial begin
    n_cmp  = 0;
    n_err  = 0;
    Reset  = 1'b1;
    key_in = 10'h3FF;
    Layer  = 4'd0;

    // Reset with keys held
    tick(2);
    check_eq("rst_buttons", 32'(buttons), 32'h0);
    check_eq("rst_door", 32'(door_open), 32'h0);
    check_eq("rst_dwell", 32'(dwell_floor), 32'h0);
    Reset  = 1'b0;
    key_in = 10'h000;
    tick(10);
    check_eq("no_latch_after_rst", 32'(buttons), 32'h0);

    // Latch latency and held-key single press
    key_in[5] = 1'b1;
    tick(6);
    check_eq("latch_edge6", 32'(buttons), 32'h0);
    tick(1);
    check_eq("latch_edge7", 32'(buttons), 32'h020);
    tick(3);
    check_eq("latch_held", 32'(buttons), 32'h020);
    key_in[5] = 1'b0;
    tick(8);
    check_eq("latch_release", 32'(buttons), 32'h020);
    check_eq("latch_door", 32'(door_open), 32'h0);

    // Glitch shorter than the debounce window
    key_in[3] = 1'b1;
    tick(3);
    key_in[3] = 1'b0;
    tick(10);
    check_eq("glitch", 32'(buttons), 32'h020);

    // Plain dwell at floor 5, Layer changes ignored, press on floor 2 mid-dwell
    Layer = 4'd5;
    tick(1);
    check_eq("dwell_open", 32'(door_open), 32'h1);
    check_eq("dwell_floor", 32'(dwell_floor), 32'h5);
    Layer     = 4'd3;
    key_in[2] = 1'b1;
    door_cnt  = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (door_open) door_cnt++;
    end
    check_eq("dwell_mid_cycles", 32'(door_cnt), 32'd6);
    tick(1);
    check_eq("dwell_last_door", 32'(door_open), 32'h1);
    check_eq("dwell_last_btn", 32'(buttons), 32'h024);
    check_eq("dwell_floor_held", 32'(dwell_floor), 32'h5);
    tick(1);
    check_eq("dwell_close_door", 32'(door_open), 32'h0);
    check_eq("dwell_close_btn", 32'(buttons), 32'h004);
    key_in[2] = 1'b0;
    tick(8);

    // Re-press on the dwell floor while the timer reads 2
    key_in[5] = 1'b1;
    tick(7);
    check_eq("repress_latch", 32'(buttons), 32'h024);
    key_in[5] = 1'b0;
    tick(8);
    Layer     = 4'd5;
    key_in[5] = 1'b1;
    tick(1);
    check_eq("repress_open", 32'(door_open), 32'h1);
    Layer = 4'd0;
    tick(6);
    check_eq("repress_reload", 32'(door_open), 32'h1);
    tick(7);
    check_eq("repress_ext_last", 32'(door_open), 32'h1);
    check_eq("repress_btn_held", 32'(buttons), 32'h024);
    tick(1);
    check_eq("repress_close", 32'(door_open), 32'h0);
    check_eq("repress_clear", 32'(buttons), 32'h004);
    key_in[5] = 1'b0;
    tick(8);

    // Press landing on the clear edge: set wins, dwell restarts
    key_in[5] = 1'b1;
    tick(7);
    key_in[5] = 1'b0;
    tick(8);
    Layer = 4'd5;
    tick(2);
    key_in[5] = 1'b1;
    tick(7);
    check_eq("clredge_door", 32'(door_open), 32'h0);
    check_eq("clredge_btn", 32'(buttons), 32'h024);
    tick(1);
    check_eq("clredge_reopen", 32'(door_open), 32'h1);
    check_eq("clredge_floor", 32'(dwell_floor), 32'h5);
    Layer     = 4'd0;
    key_in[5] = 1'b0;
    tick(7);
    check_eq("clredge_last", 32'(door_open), 32'h1);
    tick(1);
    check_eq("clredge_close", 32'(door_open), 32'h0);
    check_eq("clredge_clear", 32'(buttons), 32'h004);
    tick(8);

    // Serve floor 2, then out-of-range Layer and cancel behaviour on floor 7
    Layer = 4'd2;
    tick(10);
    check_eq("serve2_btn", 32'(buttons), 32'h0);
    check_eq("serve2_door", 32'(door_open), 32'h0);
    Layer     = 4'd12;
    key_in[7] = 1'b1;
    tick(7);
    check_eq("b7_set", 32'(buttons), 32'h080);
    check_eq("layer_oor_door", 32'(door_open), 32'h0);
    Layer     = 4'd2;
    key_in[7] = 1'b0;
    tick(8);
    key_in[7] = 1'b1;
    tick(6);
    check_eq("b7_before", 32'(buttons), 32'h080);
    tick(1);
`ifdef REQ_CANCEL_EN
    exp_b7 = 10'h000;
`else
    exp_b7 = 10'h080;
`endif
    check_eq("b7_repress", 32'(buttons), 32'(exp_b7));
    key_in[7] = 1'b0;
    tick(8);

    // Two keys debounced on the same edge
    key_in = 10'h300;
    tick(6);
    check_eq("multi_edge6", 32'(buttons), 32'(exp_b7));
    tick(1);
    check_eq("multi_edge7", 32'(buttons), 32'(exp_b7 | 10'h300));
    key_in = 10'h000;
    tick(8);

    // Reset during a dwell
    key_in[1] = 1'b1;
    tick(7);
    key_in[1] = 1'b0;
    Layer     = 4'd1;
    tick(1);
    check_eq("rstdw_open", 32'(door_open), 32'h1);
    tick(2);
    Reset = 1'b1;
    tick(1);
    check_eq("rstdw_door", 32'(door_open), 32'h0);
    check_eq("rstdw_btn", 32'(buttons), 32'h0);
    check_eq("rstdw_floor", 32'(dwell_floor), 32'h0);
    Reset = 1'b0;
    tick(2);
    check_eq("rstdw_stay", 32'(door_open), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
